uart_transceiver: RTL and testbench

- Self-contained 8N1 UART transceiver running on a single 50 MHz clock: a byte transmitter plus a byte receiver sharing one baud divisor.
- It is the serial PHY of the host link. The host-side controller sends sample bytes through the WR/WDATA/IDLE handshake and reads command bytes (e.g. 0xFF start, 0x00 stop) from RDATA/VALID.
- The controller may run on a slower, related clock. For that reason WR is edge-detected and VALID is stretched.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_core.sv | 95 +++++++++
 rtl/uart_tx_core.sv | 80 ++++++++
 rtl/uart_transceiver.sv | 45 ++++
 tb/tb_uart_transceiver.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: baud arithmetic, FSM state types and 8N1 frame constants
// shared by the UART transmitter and receiver cores.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START     = 1'b0;
    localparam logic STOP      = 1'b1;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    // Cycles per bit (half = 0) or per half bit (half = 1).
    function automatic int baud_div(input int freq, input int baud,
                                    input logic half);
        int d;
        d = freq / baud;
        return half ? d / 2 : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 byte receiver with centre sampling, glitch rejection
// and a stretched valid pulse for slower host clocks.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUDRATE  = 115200,
    parameter int FREQ      = 50_000_000,
    parameter int VALID_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       valid
);

    localparam int DIV  = baud_div(FREQ, BAUDRATE, 1'b0);
    localparam int HALF = baud_div(FREQ, BAUDRATE, 1'b1);
    localparam int CW   = $clog2(DIV + 1);
    localparam int VW   = $clog2(VALID_LEN + 1);

    rx_state_t     state, state_n;
    logic          sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [VW-1:0] vcnt;
    logic          fall;
    logic          tick;
    logic          good;

    assign fall  = prev & ~sync2;
    assign valid = (vcnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= R_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        tick    = (cnt == CW'(DIV - 1));
        good    = 1'b0;
        unique case (state)
            R_IDLE:  if (fall) state_n = R_START;
            R_START: begin
                // Half a bit in: a line already back high was a glitch.
                tick = (cnt == CW'(HALF - 1));
                if (tick) state_n = (sync2 == START) ? R_DATA : R_IDLE;
            end
            R_DATA: begin
                if (tick && bit_idx == 3'(DATA_BITS - 1))
                    state_n = R_STOP;
            end
            R_STOP: begin
                if (tick) begin
                    state_n = R_IDLE;
                    good    = (sync2 == STOP);
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rdata   <= '0;
            vcnt    <= '0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            if (state == R_IDLE || tick) cnt <= '0;
            else                         cnt <= cnt + CW'(1);
            if (state == R_IDLE) bit_idx <= '0;
            if (state == R_DATA && tick) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (good) begin
                rdata <= shreg;
                vcnt  <= VW'(VALID_LEN);
            end else if (vcnt != '0) begin
                vcnt <= vcnt - VW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 byte transmitter launched by a rising edge of wr;
// requests arriving while a frame is in flight are dropped.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BAUDRATE = 115200,
    parameter int FREQ     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       tx,
    output logic       idle
);

    localparam int DIV = baud_div(FREQ, BAUDRATE, 1'b0);
    localparam int CW  = $clog2(DIV + 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          wr_q;
    logic          start;
    logic          bit_done;

    assign start    = wr & ~wr_q;
    assign bit_done = (cnt == CW'(DIV - 1));
    assign idle     = (state == T_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        tx      = STOP;
        unique case (state)
            T_IDLE:  if (start) state_n = T_START;
            T_START: begin
                tx = START;
                if (bit_done) state_n = T_DATA;
            end
            T_DATA: begin
                tx = shreg[0];
                if (bit_done && bit_idx == 3'(DATA_BITS - 1))
                    state_n = T_STOP;
            end
            T_STOP:  if (bit_done) state_n = T_IDLE;
            default: state_n = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            wr_q <= wr;
            if (state == T_IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
                if (start) shreg <= wdata;
            end else if (bit_done) begin
                cnt <= '0;
                if (state == T_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: host-link serial PHY pairing the transmit and
// receive cores on one clock and one baud rate.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int BAUDRATE  = 115200,
    parameter int FREQ      = 50_000_000,
    parameter int VALID_LEN = 16
) (
    input  logic       CLOCK_50M,
    input  logic       RESET_N,
    input  logic       WR,
    input  logic [7:0] WDATA,
    output logic       TX,
    output logic       IDLE,
    input  logic       RX,
    output logic [7:0] RDATA,
    output logic       VALID
);

    uart_tx_core #(
        .BAUDRATE (BAUDRATE),
        .FREQ     (FREQ)
    ) u_tx (
        .clk   (CLOCK_50M),
        .rst_n (RESET_N),
        .wr    (WR),
        .wdata (WDATA),
        .tx    (TX),
        .idle  (IDLE)
    );

    uart_rx_core #(
        .BAUDRATE  (BAUDRATE),
        .FREQ      (FREQ),
        .VALID_LEN (VALID_LEN)
    ) u_rx (
        .clk   (CLOCK_50M),
        .rst_n (RESET_N),
        .rx    (RX),
        .rdata (RDATA),
        .valid (VALID)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: scenario tasks for the 8N1 transceiver, checked
// against frame arithmetic and a queue of expected received bytes.
module tb_uart_transceiver;

    localparam int DIV  = 50_000_000 / 115200;
    localparam int HALF = DIV / 2;
    localparam int VLEN = 16;
    localparam int LAT  = HALF + 9 * DIV + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rx = 1'b1;
    logic       tx, idle, valid;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_transceiver dut (
        .CLOCK_50M (clk),
        .RESET_N   (rst_n),
        .WR        (wr),
        .WDATA     (wdata),
        .TX        (tx),
        .IDLE      (idle),
        .RX        (rx),
        .RDATA     (rdata),
        .VALID     (valid)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed VALID pulses: rise cycle, data on rise, pulse length.
    int         rise_q[$];
    logic [7:0] data_q[$];
    int         len_q[$];
    int         start_q[$];
    int         run = 0;
    logic       vprev = 1'b0;

    always @(negedge clk) begin
        if (valid && !vprev) begin
            rise_q.push_back(cyc);
            data_q.push_back(rdata);
        end
        if (valid) run++;
        else if (vprev) begin
            len_q.push_back(run);
            run = 0;
        end
        vprev = valid;
    end

    task automatic clear_q();
        rise_q.delete();
        data_q.delete();
        len_q.delete();
        start_q.delete();
    endtask

    task automatic tx_frame(input logic [7:0] b, input int hold,
                            input bit second);
        int   bad, ibad, n;
        logic e;
        @(posedge clk); #1;
        wdata = b;
        wr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            ibad = 0;
            for (int c = 0; c < DIV; c++) begin
                @(posedge clk); #1;
                if (tx !== e) bad++;
                if (idle !== 1'b0) ibad++;
                n = k * DIV + c + 1;
                if (n == hold) wr = 1'b0;
                if (second && n == 1000) begin
                    wr = 1'b1;
                    wdata = ~b;
                end
                if (second && n == 1010) wr = 1'b0;
                if (n == 2000) wdata = 8'($urandom);
            end
            checks++;
            if (bad != 0 || ibad != 0) begin
                failures++;
                $display("FAIL tx_bit%0d byte=%02h: %0d cycles tx!=%0b, %0d cycles idle!=0",
                         k, b, bad, e, ibad);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (idle !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL tx_end byte=%02h: idle=%b tx=%b, required 1 1",
                     b, idle, tx);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stopb,
                           input int len);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        @(posedge clk); #1;
        start_q.push_back(cyc);
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            repeat (len) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (tx !== 1'b1 || idle !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: tx=%b idle=%b valid=%b, required 1 1 0",
                     tx, idle, valid);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b required 1", tx);
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got %b required 1", idle);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b required 0", valid);
        end
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdata: got %02h required 00", rdata);
        end
    endtask

    task automatic test_tx_a5();
        tx_frame(8'hA5, 1, 1'b0);
    endtask

    task automatic test_rx_back_to_back();
        logic [7:0] exp[3];
        int d;
        exp = '{8'hFF, 8'h00, 8'h3C};
        clear_q();
        for (int i = 0; i < 3; i++) rx_send(exp[i], 1'b1, DIV);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rise_q.size() != 3 || len_q.size() != 3) begin
            failures++;
            $display("FAIL rx_b2b_count: pulses=%0d ends=%0d required 3",
                     rise_q.size(), len_q.size());
        end
        for (int i = 0; i < 3 && i < rise_q.size() && i < len_q.size(); i++) begin
            d = rise_q[i] - start_q[i];
            checks++;
            if (data_q[i] !== exp[i] || len_q[i] != VLEN ||
                d < LAT - 2 || d > LAT + 1) begin
                failures++;
                $display("FAIL rx_b2b[%0d]: data=%02h len=%0d lat=%0d, required %02h %0d %0d..%0d",
                         i, data_q[i], len_q[i], d, exp[i], VLEN, LAT - 2, LAT + 1);
            end
        end
        checks++;
        if (rdata !== 8'h3C) begin
            failures++;
            $display("FAIL rx_b2b_hold: rdata=%02h required 3c", rdata);
        end
    endtask

    task automatic test_framing_error();
        clear_q();
        rx_send(8'h55, 1'b0, DIV);
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (rise_q.size() != 0 || rdata !== 8'h3C) begin
            failures++;
            $display("FAIL framing: pulses=%0d rdata=%02h, required 0 3c",
                     rise_q.size(), rdata);
        end
    endtask

    task automatic test_glitch();
        clear_q();
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (rise_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_reject: pulses=%0d required 0", rise_q.size());
        end
        rx_send(8'h81, 1'b1, DIV);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rise_q.size() != 1 || rdata !== 8'h81) begin
            failures++;
            $display("FAIL glitch_after: pulses=%0d rdata=%02h, required 1 81",
                     rise_q.size(), rdata);
        end
    endtask

    task automatic test_wr_hold();
        int bad;
        tx_frame(8'($urandom), 5, 1'b1);
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || idle !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wr_hold_quiet: %0d busy cycles required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        logic [7:0] tb_b, rb_b;
        fr = {1'b1, 8'hC3, 1'b0};
        @(posedge clk); #1;
        wdata = 8'h5A;
        wr = 1'b1;
        for (int n = 0; n < 3 * DIV + 50; n++) begin
            rx = fr[n / DIV];
            @(posedge clk); #1;
            wr = 1'b0;
        end
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: tx=%b idle=%b, required 1 1", tx, idle);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx !== 1'b1 || idle !== 1'b1 || valid !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: tx=%b idle=%b valid=%b rdata=%02h, required 1 1 0 00",
                     tx, idle, valid, rdata);
        end
        clear_q();
        tb_b = 8'($urandom);
        rb_b = 8'($urandom);
        fork
            tx_frame(tb_b, 1, 1'b0);
            rx_send(rb_b, 1'b1, DIV);
        join
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rise_q.size() != 1 || rdata !== rb_b) begin
            failures++;
            $display("FAIL reset_recover: pulses=%0d rdata=%02h, required 1 %02h",
                     rise_q.size(), rdata, rb_b);
        end
    endtask

    task automatic test_random_duplex();
        logic [7:0] tb_b, rb_b;
        int len, d;
        for (int it = 0; it < 4; it++) begin
            tb_b = 8'($urandom);
            rb_b = 8'($urandom);
            len = $urandom_range(DIV + 8, DIV - 8);
            clear_q();
            fork
                tx_frame(tb_b, 1, 1'b0);
                rx_send(rb_b, 1'b1, len);
            join
            repeat (20) @(posedge clk);
            #1;
            checks++;
            if (rise_q.size() != 1 || len_q.size() != 1) begin
                failures++;
                $display("FAIL dup%0d_count: pulses=%0d ends=%0d required 1 (len=%0d)",
                         it, rise_q.size(), len_q.size(), len);
            end else begin
                d = rise_q[0] - start_q[0];
                checks++;
                if (data_q[0] !== rb_b || len_q[0] != VLEN ||
                    d < LAT - 2 || d > LAT + 1) begin
                    failures++;
                    $display("FAIL dup%0d_rx: data=%02h len=%0d lat=%0d, required %02h %0d %0d..%0d",
                             it, data_q[0], len_q[0], d, rb_b, VLEN, LAT - 2, LAT + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_rx_back_to_back();
        test_framing_error();
        test_glitch();
        test_wr_hold();
        test_reset_mid();
        test_random_duplex();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
